// File: rtl/crc_32.sv
// Byte-serial IEEE 802.3 CRC-32 generator/checker (reflected form, one byte per clock).
// The running FCS is presented complemented and byte-swapped, so crc[31:24] goes on the wire first.
module crc_32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        vld,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    localparam logic [31:0] POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT  = 32'hFFFFFFFF;

    logic [31:0] r_p0;
    logic [31:0] c_inv;

    // Eight LSB-first shift/XOR steps, unrolled by synthesis into one cycle of XOR logic.
    function automatic logic [31:0] crc_byte(input logic [31:0] r, input logic [7:0] d);
        logic [31:0] acc;
        logic        fb;
        acc = r;
        for (int k = 0; k < 8; k++) begin
            fb  = acc[0] ^ d[k];
            acc = (acc >> 1) ^ (fb ? POLY_REFL : 32'h0);
        end
        return acc;
    endfunction

    // Stage p0: running reflected CRC register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p0 <= CRC_INIT;
        end else if (vld) begin
            r_p0 <= crc_byte(r_p0, data);
        end
    end

    // Output depends on the register only, never on data/vld.
    assign c_inv = ~r_p0;
    assign crc   = {c_inv[7:0], c_inv[15:8], c_inv[23:16], c_inv[31:24]};

endmodule

// File: tb/tb_crc_32.sv
// Bench for crc_32: known-answer table, hand-written reset/gap/residue sequences,
// and random frames checked against an MSB-first polynomial-division model.
`timescale 1ns/1ps
module tb_crc_32;

    logic        clk;
    logic        rst;
    logic        vld;
    logic [7:0]  data;
    logic [31:0] crc;

    int checks;
    int errors;

    crc_32 dut (
        .clk  (clk),
        .rst  (rst),
        .vld  (vld),
        .data (data),
        .crc  (crc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int           len;
        logic [127:0] bytes;
        logic [31:0]  exp;
    } vec_t;

    vec_t vecs[4];

    // Textbook CRC-32: MSB-first long division by 0x104C11DB7 over the wire bit
    // stream, then reflect and complement; returned in the DUT's byte-swapped layout.
    function automatic logic [31:0] model_crc(input logic [7:0] q[$]);
        logic [31:0] rem;
        logic [31:0] std;
        logic        top;
        rem = 32'hFFFFFFFF;
        foreach (q[i]) begin
            for (int k = 0; k < 8; k++) begin
                top = rem[31] ^ q[i][k];
                rem = {rem[30:0], 1'b0};
                if (top) rem = rem ^ 32'h04C11DB7;
            end
        end
        for (int j = 0; j < 32; j++) std[j] = ~rem[31-j];
        return {std[7:0], std[15:8], std[23:16], std[31:24]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        vld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        vld  = 1'b1;
        data = b;
        @(posedge clk);
        #1;
        vld  = 1'b0;
        data = $urandom_range(0, 255);
    endtask

    task automatic idle_check(input int n, input logic [31:0] exp, input string name);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check(name, crc, exp);
        end
    endtask

    logic [7:0]  q[$];
    logic [7:0]  frame[$];
    logic [31:0] fcs;
    int          gap;

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        vld    = 1'b0;
        data   = 8'h00;

        vecs[0].len = 0; vecs[0].bytes = '0; vecs[0].exp = 32'h00000000;
        vecs[1].len = 9; vecs[1].bytes = '0; vecs[1].exp = 32'h2639F4CB;
        for (int j = 0; j < 9; j++) vecs[1].bytes[8*j +: 8] = 8'h31 + 8'(j);
        vecs[2].len = 1; vecs[2].bytes = 128'h61; vecs[2].exp = 32'h43BEB7E8;
        vecs[3].len = 1; vecs[3].bytes = 128'h00; vecs[3].exp = 32'h8DEF02D2;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset value and idle stability
        check("reset_value", crc, 32'h00000000);
        idle_check(10, 32'h00000000, "reset_idle");

        // Known-answer table
        for (int i = 0; i < 4; i++) begin
            pulse_reset();
            for (int j = 0; j < vecs[i].len; j++) send_byte(vecs[i].bytes[8*j +: 8]);
            check($sformatf("vec%0d", i), crc, vecs[i].exp);
        end

        // "123456789" with random idle gaps; crc must hold the prefix value in gaps
        pulse_reset();
        q.delete();
        for (int j = 0; j < 9; j++) begin
            q.push_back(8'h31 + 8'(j));
            send_byte(8'h31 + 8'(j));
            check("gap_byte", crc, model_crc(q));
            gap = $urandom_range(0, 3);
            idle_check(gap, model_crc(q), "gap_hold");
        end
        check("gap_final", crc, 32'h2639F4CB);

        // 60-byte frame plus its own FCS leaves the residue
        pulse_reset();
        frame.delete();
        for (int j = 0; j < 60; j++) frame.push_back(8'($urandom_range(0, 255)));
        foreach (frame[j]) send_byte(frame[j]);
        fcs = model_crc(frame);
        check("frame60", crc, fcs);
        send_byte(fcs[31:24]);
        send_byte(fcs[23:16]);
        send_byte(fcs[15:8]);
        send_byte(fcs[7:0]);
        check("residue", crc, 32'h1CDF4421);

        // Same frame with one corrupted bit must not yield the residue
        pulse_reset();
        q = frame;
        gap = $urandom_range(0, 59);
        q[gap] = q[gap] ^ (8'h01 << $urandom_range(0, 7));
        foreach (q[j]) send_byte(q[j]);
        send_byte(fcs[31:24]);
        send_byte(fcs[23:16]);
        send_byte(fcs[15:8]);
        send_byte(fcs[7:0]);
        checks++;
        if (crc === 32'h1CDF4421) begin
            errors++;
            $display("FAIL corrupt_residue got %08h expected any value but 1cdf4421", crc);
        end

        // Reset mid-frame together with vld: byte dropped, history discarded
        pulse_reset();
        for (int j = 0; j < 5; j++) send_byte(8'($urandom_range(0, 255)));
        rst  = 1'b1;
        vld  = 1'b1;
        data = 8'hA5;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vld = 1'b0;
        check("midframe_rst", crc, 32'h00000000);
        for (int j = 0; j < 9; j++) send_byte(8'h31 + 8'(j));
        check("after_rst_check", crc, 32'h2639F4CB);

        // Random frames with random gaps, checked after every accepted byte
        for (int f = 0; f < 8; f++) begin
            pulse_reset();
            q.delete();
            for (int j = 0; j < int'($urandom_range(1, 40)); j++) begin
                q.push_back(8'($urandom_range(0, 255)));
                send_byte(q[$]);
                check($sformatf("rand%0d_b%0d", f, j), crc, model_crc(q));
                if ($urandom_range(0, 3) == 0) idle_check(1, model_crc(q), "rand_gap");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
